// File: rtl/scroll_mux_ctrl.sv
// Scroll-position and digit-scan sequencer for the 4-digit banner display.
// Emits the message index, active-low digit enables, base position and wrap pulse.
module scroll_mux_ctrl #(
    parameter int MUX_DIV    = 50000,
    parameter int SCROLL_DIV = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       step,
    output logic [3:0] X,
    output logic [3:0] AN,
    output logic [3:0] pos,
    output logic       wrap
);

    localparam int MW = $clog2(MUX_DIV);
    localparam int SW = $clog2(SCROLL_DIV);
    localparam logic [MW-1:0] MUX_LAST = MW'(MUX_DIV - 1);
    localparam logic [SW-1:0] SCR_LAST = SW'(SCROLL_DIV - 1);

    logic [MW-1:0] r_mux_cnt;
    logic [1:0]    r_digit;
    logic [SW-1:0] r_scr_cnt;
    logic [3:0]    r_base;
    logic          r_step_d;
    logic [3:0]    r_x;
    logic [3:0]    r_an;
    logic [3:0]    r_pos;
    logic          r_wrap;

    logic [MW-1:0] w_mux_nxt;
    logic [1:0]    w_digit_nxt;
    logic [SW-1:0] w_scr_nxt;
    logic [3:0]    w_base_nxt;
    logic          w_adv;
    logic          w_wrap_nxt;
    logic [3:0]    w_x_nxt;
    logic [3:0]    w_an_nxt;

    always_comb begin
        w_adv       = 1'b0;
        w_scr_nxt   = r_scr_cnt;
        w_mux_nxt   = r_mux_cnt + MW'(1);
        w_digit_nxt = r_digit;
        // Paused: the scroll counter holds so resuming finishes the partial step.
        if (en) begin
            if (r_scr_cnt == SCR_LAST) begin
                w_scr_nxt = '0;
                w_adv     = 1'b1;
            end else begin
                w_scr_nxt = r_scr_cnt + SW'(1);
            end
        end else begin
            w_adv = step & ~r_step_d;
        end
        w_base_nxt = w_adv ? r_base + 4'd1 : r_base;
        w_wrap_nxt = w_adv && (r_base == 4'hF);
        if (r_mux_cnt == MUX_LAST) begin
            w_mux_nxt   = '0;
            w_digit_nxt = r_digit + 2'd1;
        end
        w_x_nxt  = w_base_nxt + {2'b00, w_digit_nxt};
        w_an_nxt = (w_mux_nxt == '0) ? 4'hF : ~(4'b1000 >> w_digit_nxt);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mux_cnt <= '0;
            r_digit   <= '0;
            r_scr_cnt <= '0;
            r_base    <= '0;
            r_step_d  <= 1'b0;
            r_x       <= 4'h0;
            r_an      <= 4'hF;
            r_pos     <= 4'h0;
            r_wrap    <= 1'b0;
        end else begin
            r_mux_cnt <= w_mux_nxt;
            r_digit   <= w_digit_nxt;
            r_scr_cnt <= w_scr_nxt;
            r_base    <= w_base_nxt;
            r_step_d  <= step;
            r_x       <= w_x_nxt;
            r_an      <= w_an_nxt;
            r_pos     <= w_base_nxt;
            r_wrap    <= w_wrap_nxt;
        end
    end

    assign X    = r_x;
    assign AN   = r_an;
    assign pos  = r_pos;
    assign wrap = r_wrap;

endmodule

// File: tb/tb_scroll_mux_ctrl.sv
// Scoreboard bench for scroll_mux_ctrl with MUX_DIV=4, SCROLL_DIV=10.
// A cycle model pushes expected outputs per edge; tests pop and compare.
module tb_scroll_mux_ctrl;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       step;
    logic [3:0] X;
    logic [3:0] AN;
    logic [3:0] pos;
    logic       wrap;

    int n_cmp;
    int n_err;

    logic [12:0] sb[$];

    int m_mux;
    int m_digit;
    int m_scr;
    int m_base;
    bit m_stepd;

    scroll_mux_ctrl #(.MUX_DIV(4), .SCROLL_DIV(10)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .step(step),
        .X(X), .AN(AN), .pos(pos), .wrap(wrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        bit adv;
        bit w;
        logic [3:0] an;
        w = 1'b0;
        if (!rst_n) begin
            m_mux = 0; m_digit = 0; m_scr = 0; m_base = 0; m_stepd = 0;
        end else begin
            if (en) begin
                adv = (m_scr == 9);
                m_scr = adv ? 0 : m_scr + 1;
            end else begin
                adv = step && !m_stepd;
            end
            m_stepd = step;
            if (adv) begin
                w = (m_base == 15);
                m_base = (m_base + 1) % 16;
            end
            if (m_mux == 3) begin
                m_mux = 0;
                m_digit = (m_digit + 1) % 4;
            end else begin
                m_mux = m_mux + 1;
            end
        end
        case (m_digit)
            0: an = 4'b0111;
            1: an = 4'b1011;
            2: an = 4'b1101;
            default: an = 4'b1110;
        endcase
        if (m_mux == 0 || !rst_n) an = 4'b1111;
        sb.push_back({4'((m_base + m_digit) % 16), an, 4'(m_base), w});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [12:0] e;
        rst_n = 1'b0; en = 1'b0; step = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            e = sb.pop_front();
            n_cmp++;
            if ({X, AN, pos, wrap} !== e) begin
                n_err++;
                $display("FAIL reset_sb got=%h exp=%h", {X, AN, pos, wrap}, e);
            end
        end
        n_cmp++;
        if ({X, AN, pos, wrap} !== {4'h0, 4'hF, 4'h0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_vals got=%h exp=%h", {X, AN, pos, wrap}, 13'h01E0);
        end
        rst_n = 1'b1;
        tick();
        e = sb.pop_front();
        n_cmp++;
        if ({X, AN, pos, wrap} !== e) begin
            n_err++;
            $display("FAIL release_sb got=%h exp=%h", {X, AN, pos, wrap}, e);
        end
        n_cmp++;
        if (AN !== 4'b0111 || X !== 4'h0) begin
            n_err++;
            $display("FAIL release AN=%b X=%h exp AN=0111 X=0", AN, X);
        end
    endtask

    task automatic test_digit_scan();
        logic [12:0] e;
        int blanks;
        blanks = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            e = sb.pop_front();
            n_cmp++;
            if ({X, AN, pos, wrap} !== e) begin
                n_err++;
                $display("FAIL scan_sb cyc=%0d got=%h exp=%h", i, {X, AN, pos, wrap}, e);
            end
            if (AN == 4'hF) blanks++;
        end
        n_cmp++;
        if (blanks != 4) begin
            n_err++;
            $display("FAIL scan_blanks got=%0d exp=4", blanks);
        end
    endtask

    task automatic test_manual_step();
        logic [12:0] e;
        logic [3:0] p0;
        p0 = pos;
        for (int i = 0; i < 12; i++) begin
            step = (i < 5);
            if (i >= 6) step = (i % 2 == 0);
            tick();
            e = sb.pop_front();
            n_cmp++;
            if ({X, AN, pos, wrap} !== e) begin
                n_err++;
                $display("FAIL step_sb cyc=%0d got=%h exp=%h", i, {X, AN, pos, wrap}, e);
            end
            if (i == 5) begin
                n_cmp++;
                if (pos !== p0 + 4'd1) begin
                    n_err++;
                    $display("FAIL step_hold got=%0d exp=%0d", pos, p0 + 4'd1);
                end
            end
        end
        step = 1'b0;
        n_cmp++;
        if (pos !== p0 + 4'd4) begin
            n_err++;
            $display("FAIL step_pulses got=%0d exp=%0d", pos, p0 + 4'd4);
        end
    endtask

    task automatic test_index_wrap();
        logic [12:0] e;
        while (pos != 4'd14) begin
            step = ~step;
            tick();
            e = sb.pop_front();
            n_cmp++;
            if ({X, AN, pos, wrap} !== e) begin
                n_err++;
                $display("FAIL iw_step_sb got=%h exp=%h", {X, AN, pos, wrap}, e);
            end
            if (n_cmp > 5000) break;
        end
        step = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            e = sb.pop_front();
            n_cmp++;
            if ({X, AN, pos, wrap} !== e) begin
                n_err++;
                $display("FAIL iw_sb got=%h exp=%h", {X, AN, pos, wrap}, e);
            end
            if (AN == 4'b1101) begin
                n_cmp++;
                if (X !== 4'h0) begin
                    n_err++;
                    $display("FAIL iw_digit2 got=%h exp=0", X);
                end
            end
            if (AN == 4'b1110) begin
                n_cmp++;
                if (X !== 4'h1) begin
                    n_err++;
                    $display("FAIL iw_digit3 got=%h exp=1", X);
                end
            end
        end
    endtask

    task automatic test_autoscroll_wrap();
        logic [12:0] e;
        int wraps;
        wraps = 0;
        rst_n = 1'b0; en = 1'b1; step = 1'b0;
        tick();
        void'(sb.pop_front());
        rst_n = 1'b1;
        for (int i = 1; i <= 165; i++) begin
            step = (i % 7 == 0);
            tick();
            e = sb.pop_front();
            n_cmp++;
            if ({X, AN, pos, wrap} !== e) begin
                n_err++;
                $display("FAIL auto_sb edge=%0d got=%h exp=%h", i, {X, AN, pos, wrap}, e);
            end
            if (wrap) begin
                wraps++;
                n_cmp++;
                if (i != 160 || pos !== 4'h0) begin
                    n_err++;
                    $display("FAIL wrap_when edge=%0d pos=%0d exp edge=160 pos=0", i, pos);
                end
            end
            if (i == 10) begin
                n_cmp++;
                if (pos !== 4'd1) begin
                    n_err++;
                    $display("FAIL first_adv got=%0d exp=1", pos);
                end
            end
        end
        step = 1'b0;
        n_cmp++;
        if (wraps != 1) begin
            n_err++;
            $display("FAIL wrap_count got=%0d exp=1", wraps);
        end
    endtask

    task automatic test_pause_resume();
        logic [12:0] e;
        for (int i = 0; i < 30; i++) begin
            en = !(i >= 3 && i < 12);
            tick();
            e = sb.pop_front();
            n_cmp++;
            if ({X, AN, pos, wrap} !== e) begin
                n_err++;
                $display("FAIL pause_sb cyc=%0d got=%h exp=%h", i, {X, AN, pos, wrap}, e);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [12:0] e;
        rst_n = 1'b0; en = 1'b1; step = 1'b0;
        tick();
        void'(sb.pop_front());
        rst_n = 1'b1;
        for (int i = 1; i <= 93; i++) begin
            tick();
            e = sb.pop_front();
            n_cmp++;
            if ({X, AN, pos, wrap} !== e) begin
                n_err++;
                $display("FAIL sim_sb edge=%0d got=%h exp=%h", i, {X, AN, pos, wrap}, e);
            end
            if (i == 20) begin
                n_cmp++;
                if (AN !== 4'hF || X !== 4'h3 || pos !== 4'h2) begin
                    n_err++;
                    $display("FAIL adv_rollover AN=%b X=%h pos=%h exp 1111/3/2", AN, X, pos);
                end
            end
        end
        n_cmp++;
        if (pos !== 4'd9 || AN === 4'hF) begin
            n_err++;
            $display("FAIL pre_reset pos=%0d AN=%b exp pos=9 lit", pos, AN);
        end
        rst_n = 1'b0; step = 1'b1;
        tick();
        e = sb.pop_front();
        n_cmp++;
        if ({X, AN, pos, wrap} !== {4'h0, 4'hF, 4'h0, 1'b0} || e !== 13'h01E0) begin
            n_err++;
            $display("FAIL mid_reset got=%h exp=%h", {X, AN, pos, wrap}, 13'h01E0);
        end
        rst_n = 1'b1; step = 1'b0; en = 1'b0;
        tick();
        e = sb.pop_front();
        n_cmp++;
        if ({X, AN, pos, wrap} !== e) begin
            n_err++;
            $display("FAIL post_reset got=%h exp=%h", {X, AN, pos, wrap}, e);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        en = 1'b0;
        step = 1'b0;
        test_reset();
        test_digit_scan();
        test_manual_step();
        test_index_wrap();
        test_autoscroll_wrap();
        test_pause_resume();
        test_simultaneous();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
